// File: rtl/instruction_fetch.sv
// Instruction fetch unit: one outstanding memory read, a 2-entry {instr, pc} output FIFO,
// and branch redirect with flush and dropping of an in-flight read.
module instruction_fetch #(
  parameter int unsigned            ADDR_W   = 8,
  parameter int unsigned            INSTR_W  = 32,
  parameter logic [ADDR_W-1:0]      RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               br_valid,
  input  logic               br_cond,
  input  logic               ZF,
  input  logic [ADDR_W-1:0]  br_target,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc
);

  logic [ADDR_W-1:0]  pc_q;
  logic               pend_q;
  logic               drop_q;
  logic [ADDR_W-1:0]  req_addr_q;
  logic [1:0]         count_q;
  logic [INSTR_W-1:0] head_instr_q, tail_instr_q;
  logic [ADDR_W-1:0]  head_pc_q, tail_pc_q;

  logic taken;
  logic issue;
  logic push;
  logic pop;

  assign taken = br_valid & (~br_cond | ZF);
  // Gating with reset keeps imem_req low while reset is held, independent of the clock.
  assign issue = reset & ~pend_q & (count_q < 2'd2) & ~taken;
  assign push  = imem_ack & pend_q & ~drop_q & ~taken;
  assign pop   = out_valid & out_ready;

  assign imem_req  = issue;
  assign imem_addr = pc_q;
  assign out_valid = (count_q != 2'd0);
  assign out_instr = head_instr_q;
  assign out_pc    = head_pc_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q       <= RESET_PC;
      pend_q     <= 1'b0;
      drop_q     <= 1'b0;
      req_addr_q <= '0;
    end else begin
      if (taken) begin
        pc_q <= br_target;
      end else if (issue) begin
        pc_q <= pc_q + 1'b1;
      end

      if (issue) begin
        pend_q     <= 1'b1;
        drop_q     <= 1'b0;
        req_addr_q <= pc_q;
      end else if (pend_q && imem_ack) begin
        pend_q <= 1'b0;
      end else if (pend_q && taken) begin
        // Keep the slot busy until the stale ack returns, then discard it.
        drop_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q      <= 2'd0;
      head_instr_q <= '0;
      head_pc_q    <= '0;
      tail_instr_q <= '0;
      tail_pc_q    <= '0;
    end else if (taken) begin
      count_q <= 2'd0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) begin
            head_instr_q <= imem_rdata;
            head_pc_q    <= req_addr_q;
          end else begin
            tail_instr_q <= imem_rdata;
            tail_pc_q    <= req_addr_q;
          end
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          if (count_q == 2'd2) begin
            head_instr_q <= tail_instr_q;
            head_pc_q    <= tail_pc_q;
          end
          count_q <= count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd2) begin
            head_instr_q <= tail_instr_q;
            head_pc_q    <= tail_pc_q;
            tail_instr_q <= imem_rdata;
            tail_pc_q    <= req_addr_q;
          end else begin
            head_instr_q <= imem_rdata;
            head_pc_q    <= req_addr_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8: instruction address width in words.
REQ-002 The block SHALL have parameter INSTR_W, default 32: instruction word width.
REQ-003 The block SHALL have parameter RESET_PC, default 0: first fetch address after reset.
REQ-004 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port imem_req, output, 1 bit: a memory read is issued this cycle.
REQ-007 The block SHALL have port imem_addr, output, ADDR_W bits: the word address of the read issued this cycle.
REQ-008 The block SHALL have port imem_ack, input, 1 bit: memory returns data this cycle, one or more cycles after the request.
REQ-009 The block SHALL have port imem_rdata, input, INSTR_W bits: the instruction word, valid when imem_ack=1.
REQ-010 The block SHALL have port br_valid, input, 1 bit: the processor resolves a branch this cycle.
REQ-011 The block SHALL have port br_cond, input, 1 bit: 1 means the branch is taken only if ZF=1; 0 means it is unconditional.
REQ-012 The block SHALL have port ZF, input, 1 bit: the processor zero flag.
REQ-013 The block SHALL have port br_target, input, ADDR_W bits: the redirect address.
REQ-014 The block SHALL have port out_valid, output, 1 bit: out_instr and out_pc hold a fetched instruction.
REQ-015 The block SHALL have port out_ready, input, 1 bit: the processor accepts the instruction this cycle.
REQ-016 The block SHALL have port out_instr, output, INSTR_W bits: the head instruction.
REQ-017 The block SHALL have port out_pc, output, ADDR_W bits: the address of the head instruction.

Function
REQ-018 The block SHALL hold a fetch PC register and a 2-entry FIFO of {instr, pc}, with at most 1 memory request outstanding.
REQ-019 The block SHALL assert imem_req with imem_addr=PC only when no request is outstanding and (FIFO count + outstanding) < 2, and no taken redirect occurs this cycle; PC SHALL increment by 1 on issue, wrapping modulo 2^ADDR_W.
REQ-020 On imem_ack for a live request, the block SHALL write {imem_rdata, request address} into the FIFO tail, visible on out_* the next cycle.
REQ-021 The block SHALL drive out_valid=1 exactly when the FIFO is non-empty; a pop SHALL occur on out_valid & out_ready; out_* SHALL be undefined-safe (hold the last value) while out_valid=0.
REQ-022 The block SHALL define taken = br_valid & (!br_cond | ZF); br_valid with taken=0 SHALL have no effect.
REQ-023 On taken, the block SHALL flush the FIFO (out_valid=0 next cycle), load PC<=br_target, and mark any outstanding request as dropped; the next imem_req SHALL carry br_target.
REQ-024 A dropped request's imem_ack SHALL be discarded and SHALL NOT be written to the FIFO; no new request SHALL issue until that ack arrives.
REQ-025 If an ack arrives in the same cycle as a taken redirect, the data SHALL be discarded.
REQ-026 A taken redirect coinciding with a pop SHALL flush; the popped entry counts as delivered.
REQ-027 A simultaneous push and pop on a full FIFO SHALL NOT occur (REQ-019 guarantees this); a simultaneous push and pop at count 1 SHALL keep count at 1.
REQ-028 Ordering: out_pc values SHALL be delivered in issue order, with no duplicates or gaps between redirects.

Reset
REQ-029 While reset=0, regardless of clk: PC=RESET_PC, FIFO empty, no outstanding request, imem_req=0, out_valid=0, out_instr=0, out_pc=0.
REQ-030 The first imem_req SHALL be asserted in the first cycle after reset deasserts, with imem_addr=RESET_PC.
REQ-031 Reset asserted while a request is outstanding SHALL clear it; an ack arriving after reset SHALL be ignored.

Verification
REQ-032 Streaming: with 1-cycle ack latency, out_ready=1, and mem[a]=a+0x100, the bench SHALL observe out_pc=0,1,2,... and out_instr=0x100,0x101,... in order with no gaps.
REQ-033 Backpressure: with out_ready=0 for 10 cycles, the FIFO SHALL fill to 2, imem_req SHALL stay 0, and after release out_pc SHALL continue without loss or duplication.
REQ-034 Conditional branch: br_valid=1, br_cond=1, ZF=0, br_target=0x40 SHALL cause no change; the same with ZF=1 SHALL give next imem_addr=0x40 and first out_pc=0x40.
REQ-035 Redirect in flight: with 3-cycle ack latency, an unconditional redirect to 0x20 one cycle after a request SHALL discard the old data, and the first delivered out_pc SHALL be 0x20.
REQ-036 Wrap: starting at PC=0xFF with ADDR_W=8, the bench SHALL observe out_pc 0xFF followed by 0x00.
REQ-037 Mid-operation reset: reset=0 pulsed while a request is outstanding with a full FIFO SHALL immediately give out_valid=0 and imem_req=0, and the late ack SHALL be ignored; the first fetch after release SHALL be at RESET_PC.
